// File: rtl/stopwatch_lap.sv
// HH:MM:SS BCD stopwatch / countdown timer with a lap-time buffer that can be
// recalled onto the registered LCD digit outputs.
module stopwatch_lap #(
    parameter int unsigned CLK_HZ    = 50000000,
    parameter int unsigned LAP_DEPTH = 4,
    parameter int unsigned HOURS_MAX = 23
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_stop,
    input  logic       lap,
    input  logic       clr,
    input  logic       mode,
    input  logic       load,
    input  logic [7:0] load_h,
    input  logic [7:0] load_m,
    input  logic [7:0] load_s,
    input  logic       recall_en,
    input  logic [3:0] recall_idx,
    output logic [3:0] H1,
    output logic [3:0] H0,
    output logic [3:0] M1,
    output logic [3:0] M0,
    output logic [3:0] S1,
    output logic [3:0] S0,
    output logic       running,
    output logic       done,
    output logic [4:0] lap_count,
    output logic       lap_full
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    localparam int unsigned   PW       = $clog2(CLK_HZ);
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_HZ - 1);
    localparam logic [7:0]    HMAX_BCD = {4'(HOURS_MAX / 10), 4'(HOURS_MAX % 10)};

    state_t        state_q, state_d;
    logic          dir_q, dir_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [23:0]   time_q, time_d;
    logic [4:0]    lap_cnt_q, lap_cnt_d;
    logic [23:0]   laps_q [LAP_DEPTH];
    logic [23:0]   laps_d [LAP_DEPTH];
    logic [23:0]   disp_q, disp_d;
    logic          done_q, done_d;
    logic          tick;
    logic          full;
    logic [7:0]    h_n, m_n, s_n;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
        return {v[7:4], v[3:0] - 4'd1};
    endfunction

    function automatic logic [3:0] sat9(input logic [3:0] n);
        return (n > 4'd9) ? 4'd9 : n;
    endfunction

    function automatic logic [7:0] clamp_ms(input logic [7:0] v);
        logic [3:0] t;
        logic [3:0] u;
        t = sat9(v[7:4]);
        u = sat9(v[3:0]);
        if (t > 4'd5) return 8'h59;
        return {t, u};
    endfunction

    function automatic logic [7:0] clamp_h(input logic [7:0] v);
        logic [3:0] t;
        logic [3:0] u;
        logic [6:0] val;
        t   = sat9(v[7:4]);
        u   = sat9(v[3:0]);
        val = 7'(t) * 7'd10 + 7'(u);
        if (32'(val) > HOURS_MAX) return HMAX_BCD;
        return {t, u};
    endfunction

    assign tick = (state_q == RUN) && (presc_q == PRE_LAST);
    assign full = (lap_cnt_q == 5'(LAP_DEPTH));

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        presc_d   = presc_q;
        time_d    = time_q;
        lap_cnt_d = lap_cnt_q;
        laps_d    = laps_q;
        done_d    = 1'b0;
        h_n       = time_q[23:16];
        m_n       = time_q[15:8];
        s_n       = time_q[7:0];

        if (clr) begin
            state_d   = IDLE;
            time_d    = '0;
            presc_d   = '0;
            lap_cnt_d = '0;
        end else begin
            if (state_q == RUN) begin
                presc_d = tick ? '0 : presc_q + PW'(1);
                if (tick) begin
                    if (!dir_q) begin
                        if (s_n != 8'h59) s_n = bcd_inc(s_n);
                        else begin
                            s_n = '0;
                            if (m_n != 8'h59) m_n = bcd_inc(m_n);
                            else begin
                                m_n = '0;
                                h_n = (h_n != HMAX_BCD) ? bcd_inc(h_n) : '0;
                            end
                        end
                    end else if (time_q != '0) begin
                        if (s_n != 8'h00) s_n = bcd_dec(s_n);
                        else begin
                            s_n = 8'h59;
                            if (m_n != 8'h00) m_n = bcd_dec(m_n);
                            else begin
                                m_n = 8'h59;
                                h_n = bcd_dec(h_n);
                            end
                        end
                    end
                    time_d = {h_n, m_n, s_n};
                    if (dir_q && ({h_n, m_n, s_n} == '0)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
            end

            // A load pulse seen while running is dropped and does not mask start_stop/lap.
            if (load && (state_q != RUN)) begin
                time_d  = {clamp_h(load_h), clamp_ms(load_m), clamp_ms(load_s)};
                presc_d = '0;
                if (state_q == DONE) state_d = IDLE;
            end else if (start_stop) begin
                case (state_q)
                    IDLE: begin
                        state_d = RUN;
                        dir_d   = mode;
                        presc_d = '0;
                    end
                    RUN:     if (state_d != DONE) state_d = PAUSE;
                    PAUSE:   state_d = RUN;
                    default: state_d = state_q;
                endcase
            end else if (lap && ((state_q == RUN) || (state_q == PAUSE)) && !full) begin
                for (int unsigned i = 0; i < LAP_DEPTH; i++) begin
                    if (5'(i) == lap_cnt_q) laps_d[i] = time_q;
                end
                lap_cnt_d = lap_cnt_q + 5'd1;
            end
        end

        disp_d = time_q;
        if (recall_en) begin
            disp_d = '1;
            if ({1'b0, recall_idx} < lap_cnt_q) begin
                for (int unsigned i = 0; i < LAP_DEPTH; i++) begin
                    if (4'(i) == recall_idx) disp_d = laps_q[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            dir_q     <= 1'b0;
            presc_q   <= '0;
            time_q    <= '0;
            lap_cnt_q <= '0;
            disp_q    <= '0;
            done_q    <= 1'b0;
            for (int unsigned i = 0; i < LAP_DEPTH; i++) laps_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            presc_q   <= presc_d;
            time_q    <= time_d;
            lap_cnt_q <= lap_cnt_d;
            disp_q    <= disp_d;
            done_q    <= done_d;
            laps_q    <= laps_d;
        end
    end

    assign {H1, H0, M1, M0, S1, S0} = disp_q;
    assign running   = (state_q == RUN);
    assign done      = done_q;
    assign lap_count = lap_cnt_q;
    assign lap_full  = full;

endmodule

// File: tb/tb_stopwatch_lap.sv
// Directed plus random bench for stopwatch_lap, checked against a seconds-based
// behavioural model of the stopwatch.
module tb_stopwatch_lap;

    localparam int CLK_HZ    = 4;
    localparam int LAP_DEPTH = 4;
    localparam int HOURS_MAX = 23;
    localparam int DAY_SECS  = (HOURS_MAX + 1) * 3600;

    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_PAUSE = 2;
    localparam int S_DONE  = 3;

    logic       clk;
    logic       reset;
    logic       start_stop, lap, clr, mode, load, recall_en;
    logic [7:0] load_h, load_m, load_s;
    logic [3:0] recall_idx;
    logic [3:0] H1, H0, M1, M0, S1, S0;
    logic       running, done, lap_full;
    logic [4:0] lap_count;
    logic [23:0] dig;

    int n_cmp;
    int n_bad;

    int          m_sec;
    int          m_presc;
    int          m_st;
    bit          m_dir;
    int          m_laps[$];
    logic [23:0] m_disp;
    bit          m_done;

    stopwatch_lap #(
        .CLK_HZ   (CLK_HZ),
        .LAP_DEPTH(LAP_DEPTH),
        .HOURS_MAX(HOURS_MAX)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start_stop(start_stop),
        .lap       (lap),
        .clr       (clr),
        .mode      (mode),
        .load      (load),
        .load_h    (load_h),
        .load_m    (load_m),
        .load_s    (load_s),
        .recall_en (recall_en),
        .recall_idx(recall_idx),
        .H1        (H1),
        .H0        (H0),
        .M1        (M1),
        .M0        (M0),
        .S1        (S1),
        .S0        (S0),
        .running   (running),
        .done      (done),
        .lap_count (lap_count),
        .lap_full  (lap_full)
    );

    assign dig = {H1, H0, M1, M0, S1, S0};

    always #5 clk = ~clk;

    function automatic logic [23:0] to_bcd(input int s);
        int h, m, sc;
        h  = s / 3600;
        m  = (s / 60) % 60;
        sc = s % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(sc / 10), 4'(sc % 10)};
    endfunction

    function automatic int nib(input logic [3:0] n);
        return (n > 4'd9) ? 9 : int'(n);
    endfunction

    function automatic int load_secs(input logic [7:0] lh, input logic [7:0] lm, input logic [7:0] ls);
        int h, m, s;
        h = nib(lh[7:4]) * 10 + nib(lh[3:0]);
        m = nib(lm[7:4]) * 10 + nib(lm[3:0]);
        s = nib(ls[7:4]) * 10 + nib(ls[3:0]);
        if (h > HOURS_MAX) h = HOURS_MAX;
        if (m > 59) m = 59;
        if (s > 59) s = 59;
        return h * 3600 + m * 60 + s;
    endfunction

    function automatic void model_reset();
        m_sec   = 0;
        m_presc = 0;
        m_st    = S_IDLE;
        m_dir   = 1'b0;
        m_laps.delete();
        m_disp  = '0;
        m_done  = 1'b0;
    endfunction

    // Applies one clock edge to the model using the inputs currently driven.
    function automatic void model_edge();
        int  st0, sec0;
        bit  tick;
        st0  = m_st;
        sec0 = m_sec;
        if (recall_en) m_disp = (int'(recall_idx) < m_laps.size()) ? to_bcd(m_laps[recall_idx]) : 24'hFFFFFF;
        else           m_disp = to_bcd(m_sec);
        m_done = 1'b0;
        tick   = (st0 == S_RUN) && (m_presc == CLK_HZ - 1);
        if (clr) begin
            m_st    = S_IDLE;
            m_sec   = 0;
            m_presc = 0;
            m_laps.delete();
            return;
        end
        if (st0 == S_RUN) begin
            m_presc = (m_presc + 1) % CLK_HZ;
            if (tick) begin
                if (!m_dir) m_sec = (m_sec + 1) % DAY_SECS;
                else begin
                    if (m_sec > 0) m_sec = m_sec - 1;
                    if (m_sec == 0) begin
                        m_st   = S_DONE;
                        m_done = 1'b1;
                    end
                end
            end
        end
        if (load && st0 != S_RUN) begin
            m_sec   = load_secs(load_h, load_m, load_s);
            m_presc = 0;
            if (st0 == S_DONE) m_st = S_IDLE;
        end else if (start_stop) begin
            if (st0 == S_IDLE) begin
                m_st    = S_RUN;
                m_dir   = mode;
                m_presc = 0;
            end else if (st0 == S_PAUSE) m_st = S_RUN;
            else if (st0 == S_RUN && m_st != S_DONE) m_st = S_PAUSE;
        end else if (lap && (st0 == S_RUN || st0 == S_PAUSE) && m_laps.size() < LAP_DEPTH) begin
            m_laps.push_back(sec0);
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("digits",    32'(dig),       32'(m_disp));
        chk("running",   32'(running),   32'(m_st == S_RUN));
        chk("done",      32'(done),      32'(m_done));
        chk("lap_count", 32'(lap_count), 32'(m_laps.size()));
        chk("lap_full",  32'(lap_full),  32'(m_laps.size() == LAP_DEPTH));
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_model();
        start_stop = 1'b0;
        lap        = 1'b0;
        clr        = 1'b0;
        load       = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        clk = 1'b0;
        reset = 1'b0;
        start_stop = 1'b0; lap = 1'b0; clr = 1'b0; mode = 1'b0; load = 1'b0;
        load_h = '0; load_m = '0; load_s = '0;
        recall_en = 1'b0; recall_idx = '0;
        model_reset();

        #12;
        check_model();
        chk("rst_digits", 32'(dig), 32'h0);
        #10 reset = 1'b1;

        // Up count to 00:01:01, then pause and hold.
        start_stop = 1'b1; step();
        repeat (245) step();
        chk("t1_time", 32'(dig), 32'h000101);
        chk("t1_run", 32'(running), 32'h1);
        start_stop = 1'b1; step();
        chk("t1_paused", 32'(running), 32'h0);
        repeat (20) begin
            step();
            chk("t1_hold", 32'(dig), 32'h000101);
        end

        // Up-count wrap past HOURS_MAX:59:59.
        clr = 1'b1; step();
        load = 1'b1; load_h = 8'h23; load_m = 8'h59; load_s = 8'h58; mode = 1'b0; step();
        start_stop = 1'b1; step();
        repeat (9) step();
        chk("t2_wrap", 32'(dig), 32'h000000);
        repeat (8) step();
        chk("t2_cont", 32'(dig), 32'h000002);

        // Countdown from 00:01:00 to DONE.
        clr = 1'b1; step();
        mode = 1'b1; load = 1'b1; load_h = 8'h00; load_m = 8'h01; load_s = 8'h00; step();
        start_stop = 1'b1; step();
        repeat (5) step();
        chk("t3_59", 32'(dig), 32'h000059);
        repeat (235) step();
        chk("t3_done", 32'(done), 32'h1);
        chk("t3_stop", 32'(running), 32'h0);
        step();
        chk("t3_done_off", 32'(done), 32'h0);
        chk("t3_zero", 32'(dig), 32'h000000);
        start_stop = 1'b1; step();
        step();
        chk("t3_ignored", 32'(running), 32'h0);

        // Lap buffer fill, recall and clear.
        clr = 1'b1; step();
        mode = 1'b0; start_stop = 1'b1; step();
        for (int i = 0; i < 5; i++) begin
            repeat ((i == 0) ? 5 : 3) step();
            lap = 1'b1; step();
        end
        chk("t4_count", 32'(lap_count), 32'd4);
        chk("t4_full", 32'(lap_full), 32'h1);
        recall_en = 1'b1; recall_idx = 4'd3; step();
        chk("t4_recall3", 32'(dig), 32'h000004);
        recall_idx = 4'd4; step();
        chk("t4_blank", 32'(dig), 32'hFFFFFF);
        recall_en = 1'b0; clr = 1'b1; step();
        chk("t4_clr_count", 32'(lap_count), 32'd0);
        step();
        chk("t4_clr_digits", 32'(dig), 32'h000000);

        // Simultaneous clr+load+start_stop, then a lap coincident with a tick.
        mode = 1'b0; start_stop = 1'b1; step();
        repeat (6) step();
        clr = 1'b1; load = 1'b1; load_h = 8'h12; load_m = 8'h34; load_s = 8'h56; start_stop = 1'b1; step();
        step();
        chk("t5_digits", 32'(dig), 32'h000000);
        chk("t5_idle", 32'(running), 32'h0);
        start_stop = 1'b1; step();
        repeat (39) step();
        lap = 1'b1; step();
        recall_en = 1'b1; recall_idx = 4'd0; step();
        chk("t5_lap_tick", 32'(dig), 32'h000009);
        recall_en = 1'b0;

        // Load clamp, then asynchronous reset while running.
        clr = 1'b1; step();
        load = 1'b1; load_h = 8'h45; load_m = 8'h99; load_s = 8'h77; step();
        step();
        chk("t6_clamp", 32'(dig), 32'h235959);
        mode = 1'b0; start_stop = 1'b1; step();
        repeat (10) step();
        #2 reset = 1'b0;
        model_reset();
        #1;
        check_model();
        chk("t6_rst_digits", 32'(dig), 32'h000000);
        chk("t6_rst_run", 32'(running), 32'h0);
        #2 reset = 1'b1;

        // Random pulses against the model.
        repeat (3000) begin
            clr        = ($urandom_range(0, 99) == 0);
            load       = ($urandom_range(0, 99) < 3);
            start_stop = ($urandom_range(0, 99) < 6);
            lap        = ($urandom_range(0, 99) < 8);
            mode       = 1'($urandom_range(0, 1));
            recall_en  = ($urandom_range(0, 3) == 0);
            recall_idx = 4'($urandom_range(0, 15));
            load_h     = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            load_m     = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            load_s     = 8'($urandom);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
